// File: rtl/tdm_pkg.sv
// ----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM serial link (serializer and demultiplexer).
//
// Contents:
//   tdm_state_e    receiver FSM encoding (HUNT = 1'b0, RUN = 1'b1)
//   TDM_N_CH_DEF   default channel count per frame
//   TDM_PAR_SLOTS  number of trailing parity slots per frame (0 or 1)
//   tdm_parity()   XOR reduction used for the even-parity slot; a result of
//                  1 over data+parity bits means the frame is corrupt
//
// Build option: PAR_CHK_EN adds one even-parity slot after the data slots.
// ----------------------------------------------------------------------------
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } tdm_state_e;

    localparam int TDM_N_CH_DEF = 8;

`ifdef PAR_CHK_EN
    localparam int TDM_PAR_SLOTS = 1;
`else
    localparam int TDM_PAR_SLOTS = 0;
`endif

    // Wide enough for 16 data slots plus the parity slot; callers zero-extend.
    localparam int TDM_PAR_MAX_W = 17;

    function automatic logic tdm_parity(input logic [TDM_PAR_MAX_W-1:0] bits_i);
        return ^bits_i;
    endfunction

endpackage : tdm_pkg

// File: rtl/tdm_slot_ctr.sv
// ----------------------------------------------------------------------------
// tdm_slot_ctr
// Enable-gated slot counter for the TDM receiver. Holds the index of the slot
// that the next enabled sample belongs to.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset (counter -> 0)
//   en_i     in   sample enable; counter only moves on en_i=1 cycles
//   clr_i    in   clear to 0 (end of frame)              -- highest priority
//   load1_i  in   load 1 (a sync bit was taken as slot 0)
//   inc_i    in   advance to the next slot
//   slot_o   out  current slot index
// ----------------------------------------------------------------------------
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int SLOT_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              load1_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] slot_o
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (en_i) begin
            if (clr_i) begin
                slot_d = '0;
            end else if (load1_i) begin
                slot_d = SLOT_W'(1);
            end else if (inc_i) begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux.sv
// ----------------------------------------------------------------------------
// tdm_demux
// Receive end of the TDM N:1 serial link. Rebuilds N_CH parallel channel bits
// from one serial bit per enabled cycle, aligned by a sync marker that is high
// together with the slot-0 bit.
//
// Input qualifier: en is a pure sample strobe (no backpressure). On en=1 the
// pair {din, sync} is consumed on the rising edge; on en=0 nothing changes and
// every pulse output is 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   en           in   sample enable
//   din          in   serial data bit for the current slot
//   sync         in   frame marker, high with the slot-0 bit
//   ch_out       out  last complete frame, bit k = slot k (never partially updated)
//   frame_valid  out  1-clk pulse, ch_out updated this cycle
//   locked       out  receiver aligned to the frame
//   sync_err     out  1-clk pulse, sync protocol violation
//   par_err      out  1-clk pulse, parity mismatch (0 without PAR_CHK_EN)
//   dbg_state_o  out  current receiver FSM state
//
// Build option: PAR_CHK_EN -- frame carries N_CH data slots plus one
// even-parity slot; a bad frame raises par_err and is discarded.
// ----------------------------------------------------------------------------
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH   = TDM_N_CH_DEF,
    parameter int SLOT_W = $clog2(N_CH + TDM_PAR_SLOTS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            din,
    input  logic            sync,
    output logic [N_CH-1:0] ch_out,
    output logic            frame_valid,
    output logic            locked,
    output logic            sync_err,
    output logic            par_err,
    output tdm_state_e      dbg_state_o
);

    // LAST is the final slot of a frame; every slot before it is captured in
    // the shadow register, the last one is consumed directly on the commit.
    localparam int                LAST_I   = N_CH - 1 + TDM_PAR_SLOTS;
    localparam int                SHADOW_W = LAST_I;
    localparam logic [SLOT_W-1:0] LAST     = SLOT_W'(LAST_I);

    tdm_state_e          state_q, state_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic [N_CH-1:0]     ch_out_q, ch_out_d;
    logic                locked_q, locked_d;
    logic                fv_q, fv_d;
    logic                se_q, se_d;
    logic [SLOT_W-1:0]   slot;
    logic                slot_clr, slot_load1, slot_inc;
`ifdef PAR_CHK_EN
    logic                pe_q, pe_d;
    logic                par_bad;
`endif

    tdm_slot_ctr #(
        .SLOT_W (SLOT_W)
    ) u_slot_ctr (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en),
        .clr_i   (slot_clr),
        .load1_i (slot_load1),
        .inc_i   (slot_inc),
        .slot_o  (slot)
    );

`ifdef PAR_CHK_EN
    // din is the parity slot when this is used; data bits sit in the shadow.
    assign par_bad = tdm_parity(TDM_PAR_MAX_W'({din, shadow_q}));
`endif

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        ch_out_d   = ch_out_q;
        locked_d   = locked_q;
        fv_d       = 1'b0;
        se_d       = 1'b0;
        slot_clr   = 1'b0;
        slot_load1 = 1'b0;
        slot_inc   = 1'b0;
`ifdef PAR_CHK_EN
        pe_d       = 1'b0;
`endif
        if (en) begin
            case (state_q)
                HUNT: begin
                    // Only a sync bit can start alignment; plain bits are noise.
                    if (sync) begin
                        shadow_d[0] = din;
                        slot_load1  = 1'b1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (sync) begin
                        // Sync always restarts the frame; arriving anywhere but
                        // slot 0 means the partial frame is lost.
                        shadow_d[0] = din;
                        slot_load1  = 1'b1;
                        if (slot != '0) begin
                            se_d     = 1'b1;
                            locked_d = 1'b0;
                        end
                    end else if (slot == '0) begin
                        se_d     = 1'b1;
                        locked_d = 1'b0;
                        state_d  = HUNT;
                    end else if (slot != LAST) begin
                        for (int k = 1; k < SHADOW_W; k++) begin
                            if (slot == SLOT_W'(k)) begin
                                shadow_d[k] = din;
                            end
                        end
                        slot_inc = 1'b1;
                    end else begin
                        slot_clr = 1'b1;
`ifdef PAR_CHK_EN
                        if (par_bad) begin
                            pe_d = 1'b1;
                        end else begin
                            ch_out_d = shadow_q;
                            fv_d     = 1'b1;
                            locked_d = 1'b1;
                        end
`else
                        ch_out_d = {din, shadow_q};
                        fv_d     = 1'b1;
                        locked_d = 1'b1;
`endif
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HUNT;
            shadow_q <= '0;
            ch_out_q <= '0;
            locked_q <= 1'b0;
            fv_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            ch_out_q <= ch_out_d;
            locked_q <= locked_d;
            fv_q     <= fv_d;
            se_q     <= se_d;
        end
    end

`ifdef PAR_CHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe_q <= 1'b0;
        end else begin
            pe_q <= pe_d;
        end
    end
    assign par_err = pe_q;
`else
    assign par_err = 1'b0;
`endif

    assign ch_out      = ch_out_q;
    assign frame_valid = fv_q;
    assign locked      = locked_q;
    assign sync_err    = se_q;
    assign dbg_state_o = state_q;

endmodule : tdm_demux

// File: tb/tb_tdm_demux.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux
// Directed bench for tdm_demux. A queue-based receiver model tracks the bits
// seen since the last sync and predicts every output; a negedge process
// compares DUT against it each cycle. Literal checks pin the model to the
// hand-computed frame values. Honours PAR_CHK_EN like the design.
// ----------------------------------------------------------------------------
module tb_tdm_demux;
    import tdm_pkg::*;

    localparam int N_CH = 8;
`ifdef PAR_CHK_EN
    localparam int FRAME_LEN = N_CH + 1;
    localparam bit PAR       = 1'b1;
`else
    localparam int FRAME_LEN = N_CH;
    localparam bit PAR       = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic            din;
    logic            sync;
    logic [N_CH-1:0] ch_out;
    logic            frame_valid;
    logic            locked;
    logic            sync_err;
    logic            par_err;
    tdm_state_e      dbg_state;

    always #5 clk = ~clk;

    tdm_demux #(.N_CH(N_CH)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .din         (din),
        .sync        (sync),
        .ch_out      (ch_out),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .par_err     (par_err),
        .dbg_state_o (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int fv_cyc[$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Receiver seen as "list of bits since the last accepted sync".
    logic [N_CH-1:0] m_ch_out  = '0;
    logic            m_fv      = 1'b0;
    logic            m_locked  = 1'b0;
    logic            m_se      = 1'b0;
    logic            m_pe      = 1'b0;
    bit              m_aligned = 1'b0;
    logic            m_bits[$];
    logic [N_CH-1:0] m_word;
    int              m_ones;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ch_out  = '0;
            m_fv      = 1'b0;
            m_locked  = 1'b0;
            m_se      = 1'b0;
            m_pe      = 1'b0;
            m_aligned = 1'b0;
            m_bits.delete();
        end else begin
            m_fv = 1'b0;
            m_se = 1'b0;
            m_pe = 1'b0;
            if (en) begin
                if (!m_aligned) begin
                    if (sync) begin
                        m_bits.delete();
                        m_bits.push_back(din);
                        m_aligned = 1'b1;
                    end
                end else if (sync) begin
                    if (m_bits.size() != 0) begin
                        m_se     = 1'b1;
                        m_locked = 1'b0;
                    end
                    m_bits.delete();
                    m_bits.push_back(din);
                end else if (m_bits.size() == 0) begin
                    m_se      = 1'b1;
                    m_locked  = 1'b0;
                    m_aligned = 1'b0;
                end else begin
                    m_bits.push_back(din);
                    if (m_bits.size() == FRAME_LEN) begin
                        m_ones = 0;
                        for (int i = 0; i < FRAME_LEN; i++) m_ones += int'(m_bits[i]);
                        for (int i = 0; i < N_CH; i++) m_word[i] = m_bits[i];
                        if (!PAR || (m_ones % 2 == 0)) begin
                            m_ch_out = m_word;
                            m_fv     = 1'b1;
                            m_locked = 1'b1;
                        end else begin
                            m_pe = 1'b1;
                        end
                        m_bits.delete();
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("cyc_ch_out", 32'(ch_out), 32'(m_ch_out));
        check("cyc_frame_valid", 32'(frame_valid), 32'(m_fv));
        check("cyc_locked", 32'(locked), 32'(m_locked));
        check("cyc_sync_err", 32'(sync_err), 32'(m_se));
        check("cyc_par_err", 32'(par_err), 32'(m_pe));
        if (frame_valid === 1'b1) fv_cyc.push_back(cyc_n);
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge; the task returns just after
    // the next rising edge so registered outputs for that sample are visible.
    task automatic cyc(input logic e, input logic d, input logic s);
        en   = e;
        din  = d;
        sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic gap_cyc();
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic send_tail(input logic [7:0] data, input int from, input bit gap,
                             input bit force_par, input logic par_bit);
        for (int i = from; i < N_CH; i++) begin
            cyc(1'b1, data[i], 1'b0);
            if (gap) gap_cyc();
        end
`ifdef PAR_CHK_EN
        cyc(1'b1, force_par ? par_bit : ^data, 1'b0);
        if (gap) gap_cyc();
`endif
    endtask

    task automatic send_frame(input logic [7:0] data, input bit gap,
                              input bit force_par, input logic par_bit);
        cyc(1'b1, data[0], 1'b1);
        if (gap) gap_cyc();
        send_tail(data, 1, gap, force_par, par_bit);
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] pre_v;

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        din   = 1'b0;
        sync  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ch_out", 32'(ch_out), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // 1: single frame B2, LSB first
        send_frame(8'hB2, 1'b0, 1'b0, 1'b0);
        check("t1_frame_valid", 32'(frame_valid), 32'h1);
        check("t1_ch_out", 32'(ch_out), 32'hB2);
        check("t1_locked", 32'(locked), 32'h1);
        cyc(1'b0, 1'b0, 1'b0);
        check("t1_fv_one_clk", 32'(frame_valid), 32'h0);

        // 2: FF then 00 with en toggling
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        check("t2_ch_ff", 32'(ch_out), 32'hFF);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        check("t2_ch_00", 32'(ch_out), 32'h00);
        if (fv_cyc.size() >= 2)
            check("t2_fv_period", 32'(fv_cyc[fv_cyc.size()-1] - fv_cyc[fv_cyc.size()-2]),
                  32'(2 * FRAME_LEN));
        else
            check("t2_fv_seen", 32'(fv_cyc.size()), 32'h2);

        // 3: early sync at slot 5, realigned frame 3C
        pre_v = 8'h77;
        for (int i = 0; i < 5; i++) cyc(1'b1, pre_v[i], (i == 0));
        cyc(1'b1, 1'b0, 1'b1);  // bit 0 of 3C
        check("t3_sync_err", 32'(sync_err), 32'h1);
        check("t3_locked", 32'(locked), 32'h0);
        check("t3_ch_held", 32'(ch_out), 32'h00);
        check("t3_no_fv", 32'(frame_valid), 32'h0);
        send_tail(8'h3C, 1, 1'b0, 1'b0, 1'b0);
        check("t3_ch_3c", 32'(ch_out), 32'h3C);
        check("t3_relocked", 32'(locked), 32'h1);

        // 4: missing sync at slot 0 -> HUNT, plain bits ignored, frame 5A
        cyc(1'b1, 1'b1, 1'b0);
        check("t4_sync_err", 32'(sync_err), 32'h1);
        check("t4_locked", 32'(locked), 32'h0);
        check("t4_state_hunt", 32'(dbg_state), 32'h0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("t4_hunt_quiet", 32'(sync_err), 32'h0);
        check("t4_ch_held", 32'(ch_out), 32'h3C);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check("t4_ch_5a", 32'(ch_out), 32'h5A);
        check("t4_locked", 32'(locked), 32'h1);

        // 5: asynchronous reset at slot 4, then frame 81
        pre_v = 8'hE7;
        for (int i = 0; i < 4; i++) cyc(1'b1, pre_v[i], (i == 0));
        en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t5_async_ch_out", 32'(ch_out), 32'h0);
        check("t5_async_locked", 32'(locked), 32'h0);
        check("t5_async_state", 32'(dbg_state), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        check("t5_ch_81", 32'(ch_out), 32'h81);
        check("t5_fv", 32'(frame_valid), 32'h1);
        check("t5_sync_err", 32'(sync_err), 32'h0);

`ifdef PAR_CHK_EN
        // 6: good parity frame B2, then 01 with a wrong parity bit
        send_frame(8'hB2, 1'b0, 1'b1, 1'b0);
        check("t6_ch_b2", 32'(ch_out), 32'hB2);
        check("t6_fv", 32'(frame_valid), 32'h1);
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        check("t6_par_err", 32'(par_err), 32'h1);
        check("t6_ch_held", 32'(ch_out), 32'hB2);
        check("t6_no_fv", 32'(frame_valid), 32'h0);
        check("t6_locked", 32'(locked), 32'h1);
        cyc(1'b0, 1'b0, 1'b0);
        check("t6_pe_one_clk", 32'(par_err), 32'h0);
`endif

        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tdm_demux
